// File: rtl/matrix_pkg.sv
// Shared constants and controller state encoding for the 4x4 Q8.8 matrix engine bus.
package matrix_pkg;

    localparam int unsigned MAT_DIM = 4;
    localparam int unsigned ELEMS   = MAT_DIM * MAT_DIM;
    localparam int unsigned ELEM_W  = 16;
    localparam int unsigned BUS_W   = ELEMS * ELEM_W;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT,
        SETTLE,
        CAPTURE,
        STREAM,
        CLEAR
    } state_t;

endpackage

// File: rtl/matrix_unpack_mux.sv
// Selects one 16-bit element from a flattened 256-bit matrix bus.
module matrix_unpack_mux
    import matrix_pkg::*;
(
    input  logic [BUS_W-1:0]  bus,
    input  logic [IDX_W-1:0]  idx,
    output logic [ELEM_W-1:0] elem
);

    assign elem = bus[{idx, 4'b0000} +: ELEM_W];

endmodule

// File: rtl/matrix_stream_ctrl.sv
// Host-side initiator: gathers A/B from a word stream, runs one engine job,
// and streams the 16 result elements back out.
module matrix_stream_ctrl
    import matrix_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ELEM_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ELEM_W-1:0]  out_data,
    output logic               out_last,
    output logic               mm_start,
    output logic               mm_rst,
    output logic [BUS_W-1:0]   mm_matrix_a,
    output logic [BUS_W-1:0]   mm_matrix_b,
    input  logic               mm_done,
    input  logic [BUS_W-1:0]   mm_matrix_c,
    output logic               busy,
    output logic               err
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [TO_W-1:0]    tcnt;
    logic [IDX_W-1:0]   ocnt;
    logic [BUS_W-1:0]   c_buf;
    logic               in_fire;
    logic               out_fire;
    logic               timeout;
    logic [BUS_W-1:0]   sel_bus;
    logic [IDX_W-1:0]   sel_idx;
    logic [ELEM_W-1:0]  sel_elem;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == STREAM);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign timeout   = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));

    // CAPTURE preloads element 0 straight from the engine; STREAM prefetches the next element.
    assign sel_bus = (state == CAPTURE) ? mm_matrix_c : c_buf;
    assign sel_idx = (state == CAPTURE) ? '0 : IDX_W'(ocnt + IDX_W'(1));

    matrix_unpack_mux u_mux (
        .bus  (sel_bus),
        .idx  (sel_idx),
        .elem (sel_elem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   state_nxt = LOAD;
            LOAD:    if (in_fire && cnt == CNT_W'(2 * ELEMS - 1)) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT: begin
                if (mm_done)      state_nxt = SETTLE;
                else if (timeout) state_nxt = CLEAR;
            end
            SETTLE:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = STREAM;
            STREAM:  if (out_fire && ocnt == IDX_W'(ELEMS - 1)) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            tcnt        <= '0;
            ocnt        <= '0;
            c_buf       <= '0;
            out_data    <= '0;
            out_last    <= 1'b0;
            mm_start    <= 1'b0;
            mm_rst      <= 1'b1;
            mm_matrix_a <= '0;
            mm_matrix_b <= '0;
            busy        <= 1'b1;
            err         <= 1'b0;
        end else begin
            mm_start <= (state_nxt == START);
            mm_rst   <= (state_nxt == CLEAR);
            busy     <= (state_nxt != LOAD);

            if (state == CLEAR) begin
                cnt <= '0;
            end
            if (in_fire) begin
                if (!cnt[CNT_W-1]) mm_matrix_a[{cnt[IDX_W-1:0], 4'b0000} +: ELEM_W] <= in_data;
                else               mm_matrix_b[{cnt[IDX_W-1:0], 4'b0000} +: ELEM_W] <= in_data;
                cnt <= CNT_W'(cnt + CNT_W'(1));
            end

            case (state)
                START: tcnt <= '0;
                WAIT: begin
                    if (!mm_done) begin
                        tcnt <= TO_W'(tcnt + TO_W'(1));
                        if (timeout) err <= 1'b1;
                    end
                end
                CAPTURE: begin
                    c_buf    <= mm_matrix_c;
                    ocnt     <= '0;
                    out_data <= sel_elem;
                    out_last <= 1'b0;
                end
                STREAM: begin
                    if (out_fire) begin
                        ocnt <= sel_idx;
                        if (ocnt == IDX_W'(ELEMS - 1)) begin
                            out_data <= '0;
                            out_last <= 1'b0;
                        end else begin
                            out_data <= sel_elem;
                            out_last <= (sel_idx == IDX_W'(ELEMS - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_ctrl.sv
// Directed/random bench for matrix_stream_ctrl with a behavioural engine model.
module tb_matrix_stream_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, out_last;
    logic [15:0]  in_data, out_data;
    logic         mm_start, mm_rst, mm_done, busy, err;
    logic [255:0] mm_matrix_a, mm_matrix_b, mm_matrix_c;

    logic         in_valid2, in_ready2, out_valid2, out_ready2, out_last2;
    logic [15:0]  in_data2, out_data2;
    logic         mm_start2, mm_rst2, mm_done2, busy2, err2;
    logic [255:0] mm_matrix_a2, mm_matrix_b2, mm_matrix_c2;

    matrix_stream_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mm_start(mm_start), .mm_rst(mm_rst),
        .mm_matrix_a(mm_matrix_a), .mm_matrix_b(mm_matrix_b),
        .mm_done(mm_done), .mm_matrix_c(mm_matrix_c),
        .busy(busy), .err(err)
    );

    matrix_stream_ctrl #(.TIMEOUT_CYCLES(16), .TO_W(5)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_last(out_last2),
        .mm_start(mm_start2), .mm_rst(mm_rst2),
        .mm_matrix_a(mm_matrix_a2), .mm_matrix_b(mm_matrix_b2),
        .mm_done(mm_done2), .mm_matrix_c(mm_matrix_c2),
        .busy(busy2), .err(err2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [15:0]  words [32];
    logic [255:0] c_model;

    // Engine model state, updated at negedges.
    bit           eng_run = 1'b0;
    int           eng_cnt = 0;
    int           done_cyc = 0;
    int           starts = 0;
    int           rst_pulses = 0;
    int           last_start_cyc = 0;
    int           last_rst_cyc = 0;
    logic [255:0] snap_a = '0;
    logic [255:0] snap_b = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] pack(input int base);
        logic [255:0] r = '0;
        for (int i = 0; i < 16; i++) r[16*i +: 16] = words[base + i];
        return r;
    endfunction

    // Engine: done 70 cycles after start, result valid from the second done cycle.
    initial begin
        mm_done = 1'b0;
        mm_matrix_c = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || mm_rst) begin
                if (rst_n) begin
                    rst_pulses++;
                    last_rst_cyc = cyc;
                end
                eng_run = 1'b0;
                mm_done = 1'b0;
                mm_matrix_c = '0;
            end else begin
                if (mm_done) mm_matrix_c = c_model;
                if (mm_start) begin
                    starts++;
                    last_start_cyc = cyc;
                    snap_a = mm_matrix_a;
                    snap_b = mm_matrix_b;
                    eng_run = 1'b1;
                    eng_cnt = 0;
                end else if (eng_run) begin
                    eng_cnt++;
                    if (eng_cnt == 70) begin
                        mm_done = 1'b1;
                        done_cyc = cyc;
                        eng_run = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_job(input bit gaps, input bit hold);
        int  acc = 0;
        int  guard = 0;
        bit  tog = 1'b0;
        while (acc < 32 && guard < 500) begin
            @(negedge clk);
            guard++;
            tog = ~tog;
            in_valid = gaps ? tog : 1'b1;
            in_data = words[acc];
            if (in_valid && in_ready) acc++;
        end
        chk("words_accepted", 256'(acc), 256'(32));
        @(negedge clk);
        in_valid = hold;
        in_data = 16'hDEAD;
        chk("start_pulse", 256'(mm_start), 256'(1));
        chk("in_ready_in_start", 256'(in_ready), 256'(0));
        chk("snap_a", snap_a, pack(0));
        chk("snap_b", snap_b, pack(16));
    endtask

    task automatic recv_job(input int stall_idx, input int stall_len, input int abort_at);
        int idx = 0;
        int stalled = 0;
        int guard = 0;
        int ir_bad = 0;
        bit first = 1'b1;
        out_ready = 1'b1;
        while (idx < 16 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (in_ready) ir_bad++;
            if (out_valid) begin
                if (first) begin
                    chk("done_to_valid", 256'(cyc - done_cyc), 256'(3));
                    first = 1'b0;
                end
                chk("out_data", 256'(out_data), 256'(32'h1000 + idx));
                chk("out_last", 256'(out_last), 256'(idx == 15));
                if (idx == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_out_valid", 256'(out_valid), 256'(0));
                    chk("abort_out_last", 256'(out_last), 256'(0));
                    chk("abort_mm_rst", 256'(mm_rst), 256'(1));
                    return;
                end
                if (idx == stall_idx && stalled < stall_len) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    if (idx == 15) begin
                        chk("a_stable", mm_matrix_a, pack(0));
                        in_valid = 1'b0;
                    end
                    idx++;
                end
            end
        end
        chk("elements_received", 256'(idx), 256'(16));
        chk("stall_cycles", 256'(stalled), 256'(stall_len));
        chk("in_ready_low_while_busy", 256'(ir_bad), 256'(0));
    endtask

    task automatic wait_load();
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("back_to_load", 256'(in_ready), 256'(1));
        chk("busy_in_load", 256'(busy), 256'(0));
    endtask

    task automatic rand_words();
        for (int i = 0; i < 32; i++) words[i] = 16'($urandom);
    endtask

    task automatic full_job(input string name, input bit gaps, input bit hold, input int stall_idx, input int stall_len);
        int r0 = rst_pulses;
        int s0 = starts;
        send_job(gaps, hold);
        recv_job(stall_idx, stall_len, -1);
        wait_load();
        chk({name, "_start_count"}, 256'(starts - s0), 256'(1));
        chk({name, "_rst_count"}, 256'(rst_pulses - r0), 256'(1));
    endtask

    initial begin
        int s;
        int guard;
        int ov2;
        int r1;
        for (int i = 0; i < 16; i++) c_model[16*i +: 16] = 16'h1000 + 16'(i);
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b1;
        mm_done2 = 1'b0; mm_matrix_c2 = '0;
        repeat (2) @(negedge clk);

        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_out_last", 256'(out_last), 256'(0));
        chk("rst_out_data", 256'(out_data), 256'(0));
        chk("rst_mm_start", 256'(mm_start), 256'(0));
        chk("rst_mm_rst", 256'(mm_rst), 256'(1));
        chk("rst_mm_a", mm_matrix_a, 256'(0));
        chk("rst_mm_b", mm_matrix_b, 256'(0));
        chk("rst_busy", 256'(busy), 256'(1));
        chk("rst_err", 256'(err), 256'(0));

        rst_n = 1'b1;
        @(negedge clk);
        chk("release_mm_rst", 256'(mm_rst), 256'(0));
        chk("release_in_ready", 256'(in_ready), 256'(1));

        // Basic directed job
        for (int i = 0; i < 16; i++) begin
            words[i] = 16'(i);
            words[16 + i] = 16'h0100 + 16'(i);
        end
        send_job(1'b0, 1'b0);
        chk("a_elem0", 256'(mm_matrix_a[15:0]), 256'(16'h0000));
        chk("b_elem15", 256'(mm_matrix_b[255:240]), 256'(16'h010F));
        recv_job(-1, 0, -1);
        wait_load();

        rand_words();
        full_job("backpressure", 1'b0, 1'b0, 7, 5);
        rand_words();
        full_job("gaps", 1'b1, 1'b1, -1, 0);

        // Reset in the middle of the stream
        rand_words();
        send_job(1'b0, 1'b0);
        recv_job(-1, 0, 4);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_abort_mm_rst", 256'(mm_rst), 256'(1));
        chk("post_abort_in_ready", 256'(in_ready), 256'(0));
        chk("post_abort_a_cleared", mm_matrix_a, 256'(0));
        @(negedge clk);
        chk("post_abort_load", 256'(in_ready), 256'(1));
        chk("post_abort_rst_done", 256'(mm_rst), 256'(0));

        rand_words();
        full_job("after_abort", 1'b0, 1'b0, $urandom_range(0, 15), $urandom_range(1, 3));
        r1 = last_rst_cyc;
        rand_words();
        full_job("back_to_back", 1'b0, 1'b0, -1, 0);
        chk("start_after_rst", 256'(last_start_cyc > r1), 256'(1));
        chk("no_err_main", 256'(err), 256'(0));

        // Timeout on the short-timeout instance whose engine never finishes
        chk("to_err_before", 256'(err2), 256'(0));
        rand_words();
        s = 0;
        guard = 0;
        while (s < 32 && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid2 = 1'b1;
            in_data2 = words[s];
            if (in_ready2) s++;
        end
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("to_start", 256'(mm_start2), 256'(1));
        chk("to_a", mm_matrix_a2, pack(0));
        chk("to_b", mm_matrix_b2, pack(16));
        s = cyc;
        guard = 0;
        ov2 = 0;
        while (!err2 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (out_valid2) ov2++;
        end
        chk("to_wait_cycles", 256'(cyc - s), 256'(17));
        chk("to_mm_rst", 256'(mm_rst2), 256'(1));
        chk("to_in_ready_clear", 256'(in_ready2), 256'(0));
        @(negedge clk);
        chk("to_back_load", 256'(in_ready2), 256'(1));
        chk("to_err_held", 256'(err2), 256'(1));
        chk("to_busy", 256'(busy2), 256'(0));
        repeat (5) @(negedge clk);
        chk("to_err_sticky", 256'(err2), 256'(1));
        chk("to_no_output", 256'(ov2), 256'(0));
        chk("to_out_last", 256'(out_last2), 256'(0));
        chk("to_out_data", 256'(out_data2), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
